mmcm_drp_reconfig: RTL and testbench

MMCM_DRP_RECONFIG -- requirements
Module: mmcm_drp_reconfig

---
 rtl/mmcm_drp_reconfig.sv | 194 +++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP reconfiguration: holds MMCM in reset, read-modify-writes up to 8 table entries, then waits for relock.
// One DRP access outstanding at a time; drp_drdy and mmcm_locked waits are bounded and abort with error.
module mmcm_drp_reconfig #(
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 4095
) (
  input  logic        clk_in1,
  input  logic        reset,
  input  logic        tbl_we,
  input  logic [2:0]  tbl_idx,
  input  logic [6:0]  tbl_addr,
  input  logic [15:0] tbl_mask,
  input  logic [15:0] tbl_data,
  input  logic [3:0]  num_entries,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam int TMAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } entry_t;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    NEXT,
    RELEASE,
    LOCK_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [3:0]    n_q, n_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt, error_nxt;

  entry_t        tbl_q [8];
  entry_t        cur;
  logic [15:0]   wr_word;

  // Table has no reset so a mid-sequence reset can be followed by a replay.
  always_ff @(posedge clk_in1) begin
    if (tbl_we && (state == IDLE)) begin
      tbl_q[tbl_idx] <= {tbl_addr, tbl_mask, tbl_data};
    end
  end

  assign cur     = tbl_q[idx[2:0]];
  // Mask bit set keeps the current register bit; clear takes the table data bit.
  assign wr_word = (drp_do & cur.mask) | (cur.data & ~cur.mask);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n_q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    error_nxt = error;
    busy      = (state != IDLE);
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    mmcm_rst  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (num_entries == 4'd0) begin
            done_nxt = 1'b1;
          end else begin
            n_nxt     = (num_entries > 4'd8) ? 4'd8 : num_entries;
            idx_nxt   = 4'd0;
            error_nxt = 1'b0;
            state_nxt = RST;
          end
        end
      end
      RST: begin
        mmcm_rst  = 1'b1;
        state_nxt = RD;
      end
      RD: begin
        mmcm_rst  = 1'b1;
        drp_den   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        mmcm_rst = 1'b1;
        if (drp_drdy) begin
          state_nxt = WR;
        end else if (cnt == DRDY_LAST) begin
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WR: begin
        mmcm_rst  = 1'b1;
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        mmcm_rst = 1'b1;
        if (drp_drdy) begin
          state_nxt = NEXT;
        end else if (cnt == DRDY_LAST) begin
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      NEXT: begin
        mmcm_rst  = 1'b1;
        idx_nxt   = idx + 4'd1;
        state_nxt = (idx_nxt == n_q) ? RELEASE : RD;
      end
      RELEASE: begin
        cnt_nxt   = '0;
        state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (mmcm_locked) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == LOCK_LAST) begin
          error_nxt = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      n_q       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      n_q   <= n_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      error <= error_nxt;
      // Address/data only move into a DEN cycle and otherwise hold.
      if (state_nxt == RD) begin
        drp_daddr <= tbl_q[idx_nxt[2:0]].addr;
      end
      if ((state == RD_WAIT) && drp_drdy) begin
        drp_di <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a DRP/MMCM responder model and an expected-transaction queue.
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig;

  localparam int DT = 255;
  localparam int LT = 4095;

  logic        clk_in1 = 1'b0;
  logic        reset = 1'b1;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_idx = '0;
  logic [6:0]  tbl_addr = '0;
  logic [15:0] tbl_mask = '0;
  logic [15:0] tbl_data = '0;
  logic [3:0]  num_entries = '0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b0;

  mmcm_drp_reconfig #(.DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
    .clk_in1(clk_in1), .reset(reset),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_mask(tbl_mask), .tbl_data(tbl_data),
    .num_entries(num_entries), .start(start), .busy(busy), .done(done), .error(error),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct packed {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
  } exp_t;

  exp_t        exp_q[$];
  logic [6:0]  m_addr [8];
  logic [15:0] m_mask [8];
  logic [15:0] m_data [8];

  int checks = 0, failures = 0;
  int cyc = 0, den_cnt = 0, done_cnt = 0, den_cyc = 0, rst_fall_cyc = 0;
  int drp_lat = 3, lock_lat = 10, cd = 0, lcnt = 0;
  bit rand_lat = 1'b0, do_ffff = 1'b1, pending = 1'b0;
  logic [6:0] pend_addr = '0;
  logic       pend_we = 1'b0;
  logic       prev_rst = 1'b0;

  function automatic logic [15:0] rd_val(input logic [6:0] a);
    return do_ffff ? 16'hFFFF : (16'h3C5A ^ {a, a, 2'b01});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk_in1) cyc++;

  // DRP responder, MMCM lock model and DEN/done monitor, all on the falling edge.
  always @(negedge clk_in1) begin : model
    exp_t e;
    bit   was_pending;
    drp_drdy = 1'b0;
    was_pending = pending;
    if (reset === 1'b1) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        cd--;
        if (cd <= 0) begin
          drp_drdy = 1'b1;
          drp_do   = pend_we ? 16'h0000 : rd_val(pend_addr);
          pending  = 1'b0;
        end
      end
      if (drp_den === 1'b1) begin
        den_cnt++;
        den_cyc = cyc;
        chk("den_one_outstanding", {31'd0, was_pending}, 32'd0);
        chk("den_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        chk("rst_held_during_den", {31'd0, mmcm_rst}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("den_addr", {25'd0, drp_daddr}, {25'd0, e.addr});
          chk("den_we", {31'd0, drp_dwe}, {31'd0, e.we});
          if (e.we) chk("den_di", {16'd0, drp_di}, {16'd0, e.di});
        end
        if (drp_lat == 0) begin
          // Response in the DEN cycle itself, never afterwards.
          drp_drdy = 1'b1;
          drp_do   = rd_val(drp_daddr);
        end else if (drp_lat > 0) begin
          pending   = 1'b1;
          cd        = rand_lat ? int'($urandom_range(1, 4)) : drp_lat;
          pend_addr = drp_daddr;
          pend_we   = drp_dwe;
        end
      end
    end
    if (done === 1'b1) done_cnt++;
    if (prev_rst === 1'b1 && mmcm_rst === 1'b0) rst_fall_cyc = cyc;
    prev_rst = mmcm_rst;
    if (mmcm_rst === 1'b1) begin
      mmcm_locked = 1'b0;
      lcnt = 0;
    end else if (mmcm_locked == 1'b0 && lock_lat >= 0) begin
      lcnt++;
      if (lcnt >= lock_lat) mmcm_locked = 1'b1;
    end
  end

  task automatic tbl_write(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                           input bit mirror);
    tbl_we = 1'b1; tbl_idx = 3'(i); tbl_addr = a; tbl_mask = m; tbl_data = d;
    @(negedge clk_in1);
    tbl_we = 1'b0;
    if (mirror) begin
      m_addr[i] = a; m_mask[i] = m; m_data[i] = d;
    end
  endtask

  task automatic push_entry(input int i, input bit with_write);
    exp_t e;
    logic [15:0] rv;
    rv = rd_val(m_addr[i]);
    e.addr = m_addr[i]; e.we = 1'b0; e.di = 16'h0;
    exp_q.push_back(e);
    if (with_write) begin
      e.we = 1'b1;
      e.di = (rv & m_mask[i]) | (m_data[i] & ~m_mask[i]);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [3:0] n);
    start = 1'b1; num_entries = n;
    @(negedge clk_in1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(negedge clk_in1);
      k++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int den0, k;
    repeat (3) @(negedge clk_in1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_den", {31'd0, drp_den}, 32'd0);
    chk("rst_dwe", {31'd0, drp_dwe}, 32'd0);
    chk("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
    chk("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    chk("rst_di", {16'd0, drp_di}, 32'd0);
    reset = 1'b0;
    @(negedge clk_in1);

    // Single entry, DO=0xFFFF after 3 cycles.
    tbl_write(0, 7'h08, 16'h1000, 16'h0041, 1'b1);
    do_ffff = 1'b1; rand_lat = 1'b0; drp_lat = 3; lock_lat = 10;
    push_entry(0, 1'b1);
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
    wait_done(200, "t1");
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    chk("t1_error", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk_in1);
    chk("t1_done_pulses", done_cnt, 32'd1);
    chk("t1_den_pulses", den_cnt - den0, 32'd2);
    chk("t1_queue_empty", exp_q.size(), 32'd0);
    chk("t1_daddr_hold", {25'd0, drp_daddr}, 32'h08);
    chk("t1_di_hold", {16'd0, drp_di}, 32'h1041);

    // Full table, random DRDY latency, with start and tbl_we poked while busy.
    for (int i = 0; i < 8; i++) begin
      tbl_write(i, 7'(8 + i), 16'($urandom), 16'($urandom), 1'b1);
    end
    do_ffff = 1'b0; rand_lat = 1'b1; drp_lat = 1; lock_lat = 7;
    for (int i = 0; i < 8; i++) push_entry(i, 1'b1);
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd8);
    repeat (4) @(negedge clk_in1);
    pulse_start(4'd1);
    tbl_write(0, 7'h55, 16'h0000, 16'hDEAD, 1'b0);
    wait_done(1000, "t2");
    repeat (3) @(negedge clk_in1);
    chk("t2_done_pulses", done_cnt, 32'd1);
    chk("t2_den_pulses", den_cnt - den0, 32'd16);
    chk("t2_queue_empty", exp_q.size(), 32'd0);
    chk("t2_error", {31'd0, error}, 32'd0);

    // Second run, num_entries=9 clamps to 8 and table must be unchanged.
    for (int i = 0; i < 8; i++) push_entry(i, 1'b1);
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd9);
    wait_done(1000, "t2b");
    repeat (3) @(negedge clk_in1);
    chk("t2b_done_pulses", done_cnt, 32'd1);
    chk("t2b_den_pulses", den_cnt - den0, 32'd16);
    chk("t2b_queue_empty", exp_q.size(), 32'd0);

    // num_entries=0: immediate done, no DRP traffic.
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd0);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk_in1);
    chk("t3_done_pulses", done_cnt, 32'd1);
    chk("t3_den_pulses", den_cnt - den0, 32'd0);

    // DRDY timeout; the only DRDY arrives in the DEN cycle and must be ignored.
    do_ffff = 1'b1; rand_lat = 1'b0; drp_lat = 0; lock_lat = 5;
    push_entry(0, 1'b0);
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd1);
    wait_done(DT + 50, "t4");
    chk("t4_timeout_latency", cyc - den_cyc, DT + 1);
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
    @(negedge clk_in1);
    chk("t4_done_one_cycle", {31'd0, done}, 32'd0);
    chk("t4_error_sticky", {31'd0, error}, 32'd1);
    chk("t4_den_pulses", den_cnt - den0, 32'd1);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // Lock timeout.
    drp_lat = 2; lock_lat = -1;
    push_entry(0, 1'b1);
    done_cnt = 0;
    pulse_start(4'd1);
    chk("t5_error_cleared", {31'd0, error}, 32'd0);
    wait_done(LT + 200, "t5");
    chk("t5_timeout_latency", cyc - rst_fall_cyc, LT + 1);
    chk("t5_error", {31'd0, error}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk_in1);
    chk("t5_done_pulses", done_cnt, 32'd1);

    // Good start clears the sticky error.
    lock_lat = 5;
    push_entry(0, 1'b1);
    pulse_start(4'd1);
    chk("t5b_error_cleared", {31'd0, error}, 32'd0);
    wait_done(200, "t5b");
    chk("t5b_error", {31'd0, error}, 32'd0);
    chk("t5b_queue_empty", exp_q.size(), 32'd0);

    // Reset during WR_WAIT, then replay of the retained table.
    tbl_write(1, 7'h0A, 16'hF00F, 16'h0AA0, 1'b1);
    do_ffff = 1'b0; drp_lat = 5;
    push_entry(0, 1'b1);
    den0 = den_cnt;
    pulse_start(4'd2);
    k = 0;
    while (!(drp_den === 1'b1 && drp_dwe === 1'b1) && k < 100) begin
      @(negedge clk_in1);
      k++;
    end
    chk("t6_write_den_seen", {31'd0, drp_dwe}, 32'd1);
    @(negedge clk_in1);
    reset = 1'b1;
    @(negedge clk_in1);
    chk("t6_busy_after_reset", {31'd0, busy}, 32'd0);
    chk("t6_mmcm_rst_after_reset", {31'd0, mmcm_rst}, 32'd0);
    @(negedge clk_in1);
    reset = 1'b0;
    repeat (10) @(negedge clk_in1);
    chk("t6_no_den_after_reset", den_cnt - den0, 32'd2);
    chk("t6_queue_empty", exp_q.size(), 32'd0);
    push_entry(0, 1'b1);
    push_entry(1, 1'b1);
    done_cnt = 0; den0 = den_cnt;
    pulse_start(4'd2);
    wait_done(300, "t6b");
    repeat (2) @(negedge clk_in1);
    chk("t6b_den_pulses", den_cnt - den0, 32'd4);
    chk("t6b_queue_empty", exp_q.size(), 32'd0);
    chk("t6b_error", {31'd0, error}, 32'd0);
    chk("t6b_done_pulses", done_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
